// File: rtl/dram_responder.sv
// ============================================================================
// Module      : dram_responder
// Description : 1024x64 word store shared by a host port (IDLE/DONE) and an
//               accelerator port (RUN) with a READ_LAT-deep read pipeline.
//               Optional macro DRAM_RESP_BYPASS_EN forwards accelerator writes
//               into pending read-pipeline entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_responder #(
   parameter int READ_LAT  = 1,
   parameter int OUT_WORDS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        host_we,
   input  logic        host_re,
   input  logic [9:0]  host_addr,
   input  logic [63:0] host_wdata,
   output logic [63:0] host_rdata,
   input  logic        start,
   input  logic        DRAMreadEn,
   input  logic [9:0]  DRAMreadAddr,
   output logic [63:0] ifmap,
   output logic        ifmap_valid,
   input  logic        DRAMwriteEn,
   input  logic [9:0]  DRAMwriteAddr,
   input  logic [63:0] DRAMwriteData,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [9:0] c_LastCnt = 10'(OUT_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [9:0]  r_wrCnt;
   logic [63:0] r_hostRdata;
   logic        r_err;
   logic [63:0] mem [1024];

   logic        r_pValid [READ_LAT];
   logic [63:0] r_pData  [READ_LAT];
   logic        w_inValid [READ_LAT];
   logic [63:0] w_inData  [READ_LAT];
`ifdef DRAM_RESP_BYPASS_EN
   logic [9:0]  r_pAddr  [READ_LAT];
`endif

   logic        w_inRun;
   logic        w_hostWr;
   logic        w_hostRd;
   logic        w_accelWr;
   logic        w_accelRd;
   logic        w_violation;
   logic [63:0] w_rdData;

   assign w_inRun     = (r_state == RUN);
   assign w_hostWr    = host_we && !w_inRun;
   assign w_hostRd    = host_re && !w_inRun;
   assign w_accelWr   = DRAMwriteEn && w_inRun;
   assign w_accelRd   = DRAMreadEn && w_inRun;
   assign w_violation = w_inRun ? (host_we || host_re) : (DRAMreadEn || DRAMwriteEn);

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (start) w_stateNext = RUN;
         RUN:     if (DRAMwriteEn && (r_wrCnt == c_LastCnt)) w_stateNext = DONE;
         DONE:    if (start) w_stateNext = RUN;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrCnt <= 10'd0;
         r_err   <= 1'b0;
      end else begin
         if (!w_inRun && (w_stateNext == RUN)) begin
            r_wrCnt <= 10'd0;
         end else if (w_accelWr) begin
            r_wrCnt <= r_wrCnt + 10'd1;
         end
         r_err <= r_err || w_violation;
      end
   end

   // ---------------- storage (never reset) ----------------
   // Host and accelerator writes are mutually exclusive by state, so one port suffices.
   always_ff @(posedge clk) begin
      if (w_accelWr) begin
         mem[DRAMwriteAddr] <= DRAMwriteData;
      end else if (w_hostWr) begin
         mem[host_addr] <= host_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hostRdata <= 64'd0;
      end else if (w_hostRd) begin
         r_hostRdata <= mem[host_addr];
      end
   end

   // ---------------- accelerator read pipeline ----------------
   always_comb begin
      w_rdData = mem[DRAMreadAddr];
`ifdef DRAM_RESP_BYPASS_EN
      if (w_accelWr && (DRAMwriteAddr == DRAMreadAddr)) begin
         w_rdData = DRAMwriteData;
      end
`endif
   end

   always_comb begin
      for (int i = 0; i < READ_LAT; i++) begin
         w_inValid[i] = 1'b0;
         w_inData[i]  = 64'd0;
      end
      w_inValid[0] = w_accelRd;
      w_inData[0]  = w_rdData;
      for (int i = 1; i < READ_LAT; i++) begin
         w_inValid[i] = r_pValid[i-1];
         w_inData[i]  = r_pData[i-1];
`ifdef DRAM_RESP_BYPASS_EN
         if (w_accelWr && (DRAMwriteAddr == r_pAddr[i-1])) begin
            w_inData[i] = DRAMwriteData;
         end
`endif
      end
   end

   // The final stage is the ifmap register itself, so it loads only on valid data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < READ_LAT; i++) begin
            r_pValid[i] <= 1'b0;
            r_pData[i]  <= 64'd0;
         end
      end else begin
         for (int i = 0; i < READ_LAT; i++) begin
            r_pValid[i] <= w_inValid[i];
            if ((i < READ_LAT - 1) || w_inValid[i]) begin
               r_pData[i] <= w_inData[i];
            end
         end
      end
   end

`ifdef DRAM_RESP_BYPASS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < READ_LAT; i++) begin
            r_pAddr[i] <= 10'd0;
         end
      end else begin
         r_pAddr[0] <= DRAMreadAddr;
         for (int i = 1; i < READ_LAT; i++) begin
            r_pAddr[i] <= r_pAddr[i-1];
         end
      end
   end
`endif

   assign host_rdata  = r_hostRdata;
   assign ifmap       = r_pData[READ_LAT-1];
   assign ifmap_valid = r_pValid[READ_LAT-1];
   assign busy        = (r_state == RUN);
   assign done        = (r_state == DONE);
   assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder (READ_LAT=3, OUT_WORDS=4); honours DRAM_RESP_BYPASS_EN.
`default_nettype none

module tb_dram_responder;
   localparam int LAT  = 3;
   localparam int OUTW = 4;
`ifdef DRAM_RESP_BYPASS_EN
   localparam logic [63:0] EXP_SAME   = 64'h2;
   localparam logic [63:0] EXP_FLIGHT = 64'h77;
`else
   localparam logic [63:0] EXP_SAME   = 64'h1;
   localparam logic [63:0] EXP_FLIGHT = 64'h0;
`endif

   logic        clk, rst, host_we, host_re, start, DRAMreadEn, DRAMwriteEn;
   logic [9:0]  host_addr, DRAMreadAddr, DRAMwriteAddr;
   logic [63:0] host_wdata, host_rdata, ifmap, DRAMwriteData;
   logic        ifmap_valid, busy, done, err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [9:0]  addr;
      logic [63:0] wdata;
      logic [63:0] expRd;
   } vec_t;
   vec_t vecs [11];

   dram_responder #(.READ_LAT(LAT), .OUT_WORDS(OUTW)) dut (
      .clk(clk), .rst(rst),
      .host_we(host_we), .host_re(host_re), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_rdata(host_rdata),
      .start(start),
      .DRAMreadEn(DRAMreadEn), .DRAMreadAddr(DRAMreadAddr),
      .ifmap(ifmap), .ifmap_valid(ifmap_valid),
      .DRAMwriteEn(DRAMwriteEn), .DRAMwriteAddr(DRAMwriteAddr),
      .DRAMwriteData(DRAMwriteData),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b0; host_we = 1'b0; host_re = 1'b0; start = 1'b0;
      DRAMreadEn = 1'b0; DRAMwriteEn = 1'b0;
      host_addr = '0; DRAMreadAddr = '0; DRAMwriteAddr = '0;
      host_wdata = '0; DRAMwriteData = '0;

      vecs[0]  = '{10'd0,    64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
      vecs[1]  = '{10'd1,    64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111};
      vecs[2]  = '{10'd2,    64'h2222_2222_2222_2222, 64'h2222_2222_2222_2222};
      vecs[3]  = '{10'd3,    64'h3333_3333_3333_3333, 64'h3333_3333_3333_3333};
      vecs[4]  = '{10'd4,    64'h4444_4444_4444_4444, 64'h4444_4444_4444_4444};
      vecs[5]  = '{10'd5,    64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0001};
      vecs[6]  = '{10'd6,    64'h6666_6666_6666_6666, 64'h6666_6666_6666_6666};
      vecs[7]  = '{10'd7,    64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777};
      vecs[8]  = '{10'd9,    64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001};
      vecs[9]  = '{10'd100,  64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
      vecs[10] = '{10'd1023, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

      // reset state
      tick(); tick();
      chk("rst_host_rdata", host_rdata, 64'd0);
      chk("rst_ifmap", ifmap, 64'd0);
      chk("rst_ifmap_valid", {63'd0, ifmap_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      rst = 1'b1;
      tick();

      // host write/readback table
      for (int i = 0; i < 11; i++) begin
         host_we = 1'b1; host_addr = vecs[i].addr; host_wdata = vecs[i].wdata;
         tick();
      end
      host_we = 1'b0;
      for (int i = 0; i < 11; i++) begin
         host_re = 1'b1; host_addr = vecs[i].addr;
         tick();
         chk($sformatf("host_rd_%0d", vecs[i].addr), host_rdata, vecs[i].expRd);
      end
      host_re = 1'b0; host_addr = 10'd0;
      tick();
      chk("host_rdata_hold", host_rdata, vecs[10].expRd);
      chk("err_after_host", {63'd0, err}, 64'd0);

      // run 1: single read latency
      start = 1'b1; tick(); start = 1'b0;
      chk("run1_busy", {63'd0, busy}, 64'd1);
      chk("run1_done", {63'd0, done}, 64'd0);
      DRAMreadEn = 1'b1; DRAMreadAddr = 10'd5;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         DRAMreadEn = 1'b0;
         chk($sformatf("rd5_valid_k%0d", k), {63'd0, ifmap_valid}, {63'd0, (k == LAT)});
      end
      chk("rd5_data", ifmap, 64'hA5A5_0000_0000_0001);
      tick();
      chk("rd5_valid_drop", {63'd0, ifmap_valid}, 64'd0);
      chk("rd5_ifmap_hold", ifmap, 64'hA5A5_0000_0000_0001);

      // back-to-back reads of addrs 0..7
      for (int j = 1; j <= LAT + 8; j++) begin
         DRAMreadEn = (j <= 8); DRAMreadAddr = 10'(j - 1);
         tick();
         if (j >= LAT && j <= LAT + 7) begin
            chk($sformatf("b2b_valid_j%0d", j), {63'd0, ifmap_valid}, 64'd1);
            chk($sformatf("b2b_data_j%0d", j), ifmap, vecs[j-LAT].expRd);
         end else begin
            chk($sformatf("b2b_idle_j%0d", j), {63'd0, ifmap_valid}, 64'd0);
         end
      end
      DRAMreadEn = 1'b0;

      // same-cycle read+write at addr 9 (write 1 of 4)
      DRAMreadEn = 1'b1; DRAMreadAddr = 10'd9;
      DRAMwriteEn = 1'b1; DRAMwriteAddr = 10'd9; DRAMwriteData = 64'h2;
      tick();
      DRAMreadEn = 1'b0; DRAMwriteEn = 1'b0;
      for (int k = 2; k <= LAT; k++) tick();
      chk("same_cycle_valid", {63'd0, ifmap_valid}, 64'd1);
      chk("same_cycle_data", ifmap, EXP_SAME);

      // write to an address with a read in flight (write 2 of 4)
      DRAMreadEn = 1'b1; DRAMreadAddr = 10'd100;
      tick();
      DRAMreadEn = 1'b0;
      DRAMwriteEn = 1'b1; DRAMwriteAddr = 10'd100; DRAMwriteData = 64'h77;
      tick();
      DRAMwriteEn = 1'b0;
      for (int k = 3; k <= LAT; k++) tick();
      chk("inflight_valid", {63'd0, ifmap_valid}, 64'd1);
      chk("inflight_data", ifmap, EXP_FLIGHT);

      // start during RUN must not restart the write count
      start = 1'b1; tick(); start = 1'b0;
      chk("start_in_run_busy", {63'd0, busy}, 64'd1);
      DRAMwriteEn = 1'b1; DRAMwriteAddr = 10'd200; DRAMwriteData = 64'hC8;
      tick();
      chk("run1_w3_done", {63'd0, done}, 64'd0);
      DRAMwriteAddr = 10'd201; DRAMwriteData = 64'hC9;
      DRAMreadEn = 1'b1; DRAMreadAddr = 10'd6;
      tick();
      DRAMwriteEn = 1'b0; DRAMreadEn = 1'b0;
      chk("run1_w4_done", {63'd0, done}, 64'd1);
      chk("run1_w4_busy", {63'd0, busy}, 64'd0);
      for (int k = 2; k <= LAT; k++) tick();
      chk("tail_read_valid", {63'd0, ifmap_valid}, 64'd1);
      chk("tail_read_data", ifmap, 64'h6666_6666_6666_6666);
      chk("run1_err", {63'd0, err}, 64'd0);

      // run 2: four writes to addrs 0..3
      start = 1'b1; tick(); start = 1'b0;
      chk("run2_busy", {63'd0, busy}, 64'd1);
      for (int i = 0; i < OUTW; i++) begin
         DRAMwriteEn = 1'b1; DRAMwriteAddr = 10'(i);
         DRAMwriteData = 64'hD000_0000_0000_0000 | 64'(i);
         tick();
         chk($sformatf("run2_done_w%0d", i), {63'd0, done}, {63'd0, (i == OUTW - 1)});
         chk($sformatf("run2_busy_w%0d", i), {63'd0, busy}, {63'd0, (i != OUTW - 1)});
      end
      DRAMwriteEn = 1'b0;
      host_re = 1'b1; host_addr = 10'd2; tick(); host_re = 1'b0;
      chk("run2_readback2", host_rdata, 64'hD000_0000_0000_0002);

      // accelerator write outside RUN
      DRAMwriteEn = 1'b1; DRAMwriteAddr = 10'd0; DRAMwriteData = 64'hBAD;
      tick();
      DRAMwriteEn = 1'b0;
      chk("err_accel_in_done", {63'd0, err}, 64'd1);
      host_re = 1'b1; host_addr = 10'd0; tick(); host_re = 1'b0;
      chk("mem_unchanged", host_rdata, 64'hD000_0000_0000_0000);

      // reset clears err
      rst = 1'b0; tick();
      chk("err_cleared", {63'd0, err}, 64'd0);
      rst = 1'b1; tick();

      // host write and start in the same IDLE cycle, then host write in RUN
      host_we = 1'b1; host_addr = 10'd300; host_wdata = 64'h3003_0000_CAFE_F00D;
      start = 1'b1; tick();
      host_we = 1'b0; start = 1'b0;
      chk("run3_busy", {63'd0, busy}, 64'd1);
      host_we = 1'b1; host_wdata = 64'hBAD;
      tick();
      host_we = 1'b0;
      chk("err_host_in_run", {63'd0, err}, 64'd1);
      for (int i = 0; i < OUTW; i++) begin
         DRAMwriteEn = 1'b1; DRAMwriteAddr = 10'(400 + i); DRAMwriteData = 64'(i);
         tick();
      end
      DRAMwriteEn = 1'b0;
      chk("run3_done", {63'd0, done}, 64'd1);
      host_re = 1'b1; host_addr = 10'd300; tick(); host_re = 1'b0;
      chk("run3_readback300", host_rdata, 64'h3003_0000_CAFE_F00D);

      // reset mid-RUN with reads in flight
      start = 1'b1; tick(); start = 1'b0;
      DRAMreadEn = 1'b1; DRAMreadAddr = 10'd5;
      tick(); tick();
      DRAMreadEn = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_done", {63'd0, done}, 64'd0);
      chk("arst_err", {63'd0, err}, 64'd0);
      chk("arst_ifmap", ifmap, 64'd0);
      chk("arst_ifmap_valid", {63'd0, ifmap_valid}, 64'd0);
      chk("arst_host_rdata", host_rdata, 64'd0);
      rst = 1'b1;
      for (int k = 1; k <= LAT + 2; k++) begin
         tick();
         chk($sformatf("post_rst_valid_k%0d", k), {63'd0, ifmap_valid}, 64'd0);
      end
      chk("post_rst_idle", {63'd0, busy}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 Parameter READ_LAT, default 1, accelerator read latency in cycles; legal range 1..4.
REQ-002 Parameter OUT_WORDS, default 32, number of accelerator writes that end a run; legal range 1..1024.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 host_we  input  1  host write strobe; used only in IDLE or DONE.
REQ-006 host_re  input  1  host read strobe; used only in IDLE or DONE.
REQ-007 host_addr  input  10  host word address.
REQ-008 host_wdata  input  64  host write data.
REQ-009 host_rdata  output  64  host read data.
REQ-010 start  input  1  single-cycle pulse that begins a run.
REQ-011 DRAMreadEn  input  1  accelerator read request.
REQ-012 DRAMreadAddr  input  10  accelerator read word address.
REQ-013 ifmap  output  64  accelerator read data.
REQ-014 ifmap_valid  output  1  marks ifmap as valid.
REQ-015 DRAMwriteEn  input  1  accelerator write strobe.
REQ-016 DRAMwriteAddr  input  10  accelerator write word address.
REQ-017 DRAMwriteData  input  64  accelerator write data.
REQ-018 busy  output  1  high while in RUN.
REQ-019 done  output  1  high while in DONE.
REQ-020 err  output  1  sticky protocol-violation flag.

Function
REQ-021 Storage SHALL be 1024 x 64-bit words, one word per address, with no wrap or out-of-range case.
REQ-022 The FSM SHALL have states IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE on the write that brings wr_cnt to OUT_WORDS, and DONE->RUN on start.
REQ-023 Entering RUN SHALL clear the 10-bit wr_cnt, and each accepted accelerator write in RUN SHALL increment it by 1.
REQ-024 In IDLE/DONE, host_we SHALL write host_wdata to host_addr.
REQ-025 In IDLE/DONE, host_re SHALL drive host_rdata with mem[host_addr] one cycle later, and host_rdata SHALL hold otherwise.
REQ-026 In RUN, host_we and host_re SHALL be ignored and err SHALL be set.
REQ-027 In RUN, DRAMreadEn at cycle N SHALL present mem[DRAMreadAddr] on ifmap with ifmap_valid=1 at cycle N+READ_LAT.
REQ-028 The read path SHALL be fully pipelined (one request per cycle), and ifmap SHALL hold its last value while ifmap_valid=0.
REQ-029 In RUN, DRAMwriteEn SHALL write DRAMwriteData to DRAMwriteAddr in the same cycle.
REQ-030 DRAMreadEn or DRAMwriteEn outside RUN SHALL be ignored and SHALL set err.
REQ-031 Read requests still in flight when RUN->DONE occurs SHALL complete normally.
REQ-032 A start pulse while in RUN SHALL be ignored.
REQ-033 If host_we and start occur in the same IDLE cycle, the write SHALL complete and RUN SHALL begin next cycle.
REQ-034 An accelerator read and write to the same address in the same cycle SHALL return old data (no macro) or new data (macro defined).

Reset
REQ-035 rst low SHALL asynchronously force state IDLE, wr_cnt=0, read pipeline valids=0, ifmap=0, ifmap_valid=0, host_rdata=0, busy=0, done=0 and err=0.
REQ-036 Memory contents SHALL NOT be reset, and a reset mid-RUN SHALL abandon the run and drop any in-flight reads.
REQ-037 err SHALL clear only on reset.

Configuration
REQ-038 With DRAM_RESP_BYPASS_EN defined, a same-cycle, same-address accelerator write SHALL be forwarded to the read pipeline entry, and a write matching any in-flight read address SHALL replace that entry's data.
REQ-039 With DRAM_RESP_BYPASS_EN undefined, the read pipeline SHALL capture memory data at request time only, with no forwarding logic.

Verification
REQ-040 Host writes mem[5]=64'hA5A5_0000_0000_0001, start, DRAMreadEn addr 5 -> ifmap=64'hA5A5_0000_0000_0001 with ifmap_valid=1 exactly READ_LAT cycles later.
REQ-041 OUT_WORDS=4, four writes to addrs 0..3 in RUN -> done=1 the cycle after the 4th write, busy=0, host readback of addr 2 returns the written data.
REQ-042 Back-to-back reads of addrs 0..7, READ_LAT=3 -> eight consecutive valid cycles in address order, no bubbles.
REQ-043 Same-cycle read+write at addr 9 (old 64'h1, new 64'h2) -> ifmap=64'h1 without macro, 64'h2 with DRAM_RESP_BYPASS_EN.
REQ-044 DRAMwriteEn in IDLE -> memory unchanged and err=1; host_we in RUN -> ignored and err=1.
REQ-045 rst low mid-RUN with reads in flight -> all outputs zero immediately, state IDLE, no ifmap_valid after release.
